// File: rtl/rca_self_checker.sv
// rca_self_checker: exhaustively sweeps (a, b, cin) into a combinational adder and checks sum/cout
module rca_self_checker #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic                 dut_cin,
  input  logic [WIDTH-1:0]     dut_sum,
  input  logic                 dut_cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic                 first_fail_valid,
  output logic [2*WIDTH:0]     first_fail_vec
);
  localparam int VW = 2*WIDTH+1;
  localparam int EW = 2*WIDTH+2;
  localparam int SW = $clog2(SETTLE_CYCLES+1);
  if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
    $error("rca_self_checker: WIDTH must be 1..8");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("rca_self_checker: SETTLE_CYCLES must be >= 1");
  end
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;
  state_t          state_q;
  logic [VW-1:0]   v_q;
  logic [SW-1:0]   settle_q;
  logic [EW-1:0]   err_q;
  logic [EW-1:0]   err_d;
  logic            ffv_q;
  logic [VW-1:0]   ffvec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [WIDTH:0]  ref_w;
  logic            mismatch;
  assign dut_cin          = v_q[0];
  assign dut_b            = v_q[WIDTH:1];
  assign dut_a            = v_q[2*WIDTH:WIDTH+1];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  // Reference is kept at WIDTH+1 bits so the carry-out is compared too
  always_comb begin
    ref_w    = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
    mismatch = ref_w != {dut_cout, dut_sum};
    err_d    = err_q + {{(EW-1){1'b0}}, mismatch};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      v_q      <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_WAIT;
            v_q      <= '0;
            settle_q <= '0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (settle_q == SW'(SETTLE_CYCLES-1)) state_q <= S_CHECK;
          else settle_q <= settle_q + 1'b1;
        end
        S_CHECK: begin
          err_q    <= err_d;
          settle_q <= '0;
          if (mismatch && !ffv_q) begin
            ffv_q   <= 1'b1;
            ffvec_q <= v_q;
          end
          if (v_q == '1) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= err_d == '0;
          end else begin
            state_q <= S_WAIT;
            v_q     <= v_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rca_self_checker.sv
// tb_rca_self_checker: drives sweeps against a fault-injectable adder; scoreboard checks each completed sweep
module tb_rca_self_checker;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] dut_a, dut_b, dut_sum;
  logic       dut_cin, dut_cout;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic       first_fail_valid;
  logic [6:0] first_fail_vec;
  logic [1:0] mode;
  logic [3:0] full;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit done_prev = 1'b0;
  typedef struct {
    int err;
    bit ffv;
    int vec;
    bit pass;
    int cyc;
  } exp_t;
  exp_t q[$];
  rca_self_checker #(.WIDTH(3), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec)
  );
  // Adder under test: mode 0 correct, 1 sum[0] stuck at 0, 2 cout stuck at 0
  assign full     = {1'b0, dut_a} + {1'b0, dut_b} + {3'b000, dut_cin};
  assign dut_sum  = mode == 2'd1 ? {full[2:1], 1'b0} : full[2:0];
  assign dut_cout = mode == 2'd2 ? 1'b0 : full[3];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done && !done_prev) begin
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no completion at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("err_count", {24'd0, err_count}, e.err);
        chk("first_fail_valid", {31'd0, first_fail_valid}, {31'd0, e.ffv});
        chk("first_fail_vec", {25'd0, first_fail_vec}, e.vec);
        chk("pass", {31'd0, pass}, {31'd0, e.pass});
        chk("busy_at_done", {31'd0, busy}, 0);
      end
    end
    done_prev = done;
  end
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_pass"}, {31'd0, pass}, 0);
    chk({tag, "_err"}, {24'd0, err_count}, 0);
    chk({tag, "_ffv"}, {31'd0, first_fail_valid}, 0);
    chk({tag, "_ffvec"}, {25'd0, first_fail_vec}, 0);
    chk({tag, "_dut_in"}, {25'd0, dut_a, dut_b, dut_cin}, 0);
  endtask
  task automatic do_start(input int err, input bit ffv, input int vec, input bit ps);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.err = err; e.ffv = ffv; e.vec = vec; e.pass = ps; e.cyc = cyc + 384;
    q.push_back(e);
    chk("busy_at_start", {31'd0, busy}, 1);
    chk("done_at_start", {31'd0, done}, 0);
    chk("err_clear_at_start", {24'd0, err_count}, 0);
    chk("ffv_clear_at_start", {31'd0, first_fail_valid}, 0);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sweep_timeout: got no done expected done within 500 cycles");
      q.delete();
    end
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("idle");
    // Correct adder; starts while busy must be ignored
    do_start(0, 1'b0, 0, 1'b1);
    repeat (4) @(negedge clk);
    pulse_start();
    repeat (44) @(negedge clk);
    pulse_start();
    chk("busy_mid_sweep", {31'd0, busy}, 1);
    wait_done();
    repeat (20) @(negedge clk);
    chk("hold_done", {31'd0, done}, 1);
    chk("hold_pass", {31'd0, pass}, 1);
    chk("hold_busy", {31'd0, busy}, 0);
    mode = 2'd1;
    do_start(64, 1'b1, 1, 1'b0);
    wait_done();
    mode = 2'd2;
    do_start(64, 1'b1, 15, 1'b0);
    wait_done();
    mode = 2'd0;
    do_start(0, 1'b0, 0, 1'b1);
    wait_done();
    // Reset mid-sweep after some errors have accumulated
    mode = 2'd1;
    do_start(64, 1'b1, 1, 1'b0);
    repeat (100) @(posedge clk);
    #3;
    chk("err_before_reset", {31'd0, err_count != 8'd0}, 1);
    rst = 1'b1;
    #1;
    chk_zero("async_reset");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_restart_busy", {31'd0, busy}, 0);
    chk("no_restart_done", {31'd0, done}, 0);
    mode = 2'd0;
    do_start(0, 1'b0, 0, 1'b1);
    wait_done();
    // Reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_beats_start_busy", {31'd0, busy}, 0);
    chk("rst_beats_start_done", {31'd0, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst_start", {31'd0, busy}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
